// File: rtl/sid_bus_master.sv
// sid_bus_master: phi2 generator and SID register-bus initiator fed by a small
// command FIFO. Optional read support is enabled with the SID_BUS_READ_EN macro.
// When the macro is undefined, read commands are accepted and dropped, and the
// read-result outputs are tied to zero.

package sid;
    typedef logic [7:0] reg8_t;

    // Bus toward sid_api. rw = 1 means a read cycle.
    typedef struct packed {
        logic [4:0] addr;
        reg8_t      data;
        logic       rw;
    } bus_i_t;

    // Chip selects toward sid_api.
    typedef struct packed {
        logic cs_n;
        logic a5;
        logic a8;
        logic cs_io1_n;
    } cs_t;
endpackage

module sid_bus_master #(
    parameter int PHI2_DIV   = 24,
    parameter int BUS_HOLD   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_rw,
    input  logic [1:0]   cmd_target,
    input  logic [4:0]   cmd_addr,
    input  logic [7:0]   cmd_data,
    output logic         phi2,
    output sid::bus_i_t  bus_o,
    output sid::cs_t     cs,
    input  sid::reg8_t   data_i,
    output logic         rd_valid,
    output logic [7:0]   rd_data,
    output logic         busy
);

    localparam int CW = $clog2(PHI2_DIV);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    localparam sid::bus_i_t BUS_IDLE = '{addr: 5'd0, data: 8'd0, rw: 1'b1};
    localparam sid::cs_t    CS_IDLE  = '{cs_n: 1'b1, a5: 1'b0, a8: 1'b0, cs_io1_n: 1'b1};

    typedef struct packed {
        logic       rw;
        logic [1:0] target;
        logic [4:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [CW-1:0] cnt, cnt_nxt;
    logic          wrap, launch;

    cmd_t          mem [FIFO_DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count;
    logic          push, pop;

    state_t        state, state_nxt;
    sid::bus_i_t   bus_nxt;
    sid::cs_t      cs_nxt;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic sid::cs_t cs_decode(input logic [1:0] t);
        sid::cs_t c;
        c = CS_IDLE;
        case (t)
            2'd0: c.cs_n = 1'b0;
            2'd1: begin c.cs_n = 1'b0; c.a5 = 1'b1; end
            2'd2: begin c.cs_n = 1'b0; c.a8 = 1'b1; end
            default: c.cs_io1_n = 1'b0;
        endcase
        return c;
    endfunction

    assign wrap    = (cnt == CW'(PHI2_DIV - 1));
    assign launch  = (cnt == CW'(BUS_HOLD));
    assign cnt_nxt = wrap ? '0 : cnt + 1'b1;

    // Phase counter; phi2 is registered from the next count so it tracks cnt exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            phi2 <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            phi2 <= (cnt_nxt >= CW'(PHI2_DIV / 2));
        end
    end

    // FIFO handshake: ready comes from the registered count only, so a pop
    // while full does not open the port in the same cycle.
    assign cmd_ready = (count != NW'(FIFO_DEPTH));
`ifdef SID_BUS_READ_EN
    assign push = cmd_valid & cmd_ready;
`else
    // Reads are swallowed at the port and never take a bus slot.
    assign push = cmd_valid & cmd_ready & ~cmd_rw;
`endif
    assign pop  = launch & (count != '0);
    assign head = mem[rd_ptr];

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{rw: cmd_rw, target: cmd_target, addr: cmd_addr, data: cmd_data};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Transaction state and next bus image, both decided only at the launch point.
    always_comb begin
        state_nxt = state;
        bus_nxt   = bus_o;
        cs_nxt    = cs;
        if (launch) begin
            if (pop) begin
                state_nxt    = ACTIVE;
                bus_nxt.addr = head.addr;
                bus_nxt.data = head.rw ? 8'd0 : head.data;
                bus_nxt.rw   = head.rw;
                cs_nxt       = cs_decode(head.target);
            end else begin
                state_nxt = IDLE;
                bus_nxt   = BUS_IDLE;
                cs_nxt    = CS_IDLE;
            end
        end
    end

    // State and bus registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bus_o <= BUS_IDLE;
            cs    <= CS_IDLE;
        end else begin
            state <= state_nxt;
            bus_o <= bus_nxt;
            cs    <= cs_nxt;
        end
    end

    assign busy = (count != '0) | (state == ACTIVE);

`ifdef SID_BUS_READ_EN
    // Capture read data at the last cycle of phi2 high; strobe on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= 8'd0;
        end else begin
            rd_valid <= wrap & (state == ACTIVE) & bus_o.rw;
            if (wrap & (state == ACTIVE) & bus_o.rw) rd_data <= data_i;
        end
    end
`else
    logic unused_data_i;
    assign unused_data_i = ^data_i;
    assign rd_valid      = 1'b0;
    assign rd_data       = 8'd0;
`endif

endmodule

// File: tb/tb_sid_bus_master.sv
// Directed bench for sid_bus_master with default parameters.
// Expected values are hand-derived from the bus timing; phase is tracked by a
// local counter that restarts on reset.
module tb_sid_bus_master;

    localparam int DIV  = 24;
    localparam int HOLD = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rw = 1'b0;
    logic [1:0]  cmd_target = 2'd0;
    logic [4:0]  cmd_addr = 5'd0;
    logic [7:0]  cmd_data = 8'd0;
    logic        phi2;
    sid::bus_i_t bus_o;
    sid::cs_t    cs;
    sid::reg8_t  data_i = 8'd0;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        busy;

    int tcnt = 0;
    int nvec = 0;
    int nerr = 0;
    int rdv_seen = 0;
    int rdv_before;

    sid_bus_master dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_target(cmd_target), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .phi2(phi2), .bus_o(bus_o), .cs(cs), .data_i(data_i),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tcnt <= rst ? 0 : ((tcnt == DIV - 1) ? 0 : tcnt + 1);

    always @(negedge clk) if (rd_valid === 1'b1) rdv_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare the whole bus image: {cs_n,a5,a8,cs_io1_n,addr,data,rw}.
    task automatic chk_bus(input string tag, input logic cs_n, input logic a5, input logic a8,
                           input logic io1, input logic rw, input logic [4:0] a, input logic [7:0] d);
        chk(tag, 32'({cs, bus_o}), 32'({cs_n, a5, a8, io1, a, d, rw}));
    endtask

    task automatic chk_idle(input string tag);
        chk_bus(tag, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 8'd0);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int k);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (tcnt != k && n < 2 * DIV);
        if (tcnt != k) chk("goto_timeout", 32'(tcnt), 32'(k));
    endtask

    task automatic drive(input logic rw, input logic [1:0] tg, input logic [4:0] a, input logic [7:0] d);
        cmd_valid  = 1'b1;
        cmd_rw     = rw;
        cmd_target = tg;
        cmd_addr   = a;
        cmd_data   = d;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_phi2", 32'(phi2), 32'd0);
        chk_idle("rst_bus");
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdv", 32'(rd_valid), 32'd0);
        chk("rst_rdd", 32'(rd_data), 32'd0);
        rst = 1'b0;

        // Single write D400/0x18/0x0F pushed at cnt 0
        drive(1'b0, 2'd0, 5'h18, 8'h0F);
        step();
        cmd_valid = 1'b0;
        chk("w1_busy_q", 32'(busy), 32'd1);
        goto(HOLD);
        chk_idle("w1_pre");
        step();
        chk_bus("w1_launch", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h18, 8'h0F);
        goto(DIV / 2);
        chk("w1_phi2_hi", 32'(phi2), 32'd1);
        chk_bus("w1_hi", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h18, 8'h0F);
        goto(0);
        chk("w1_phi2_fall", 32'(phi2), 32'd0);
        goto(HOLD);
        chk_bus("w1_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h18, 8'h0F);
        chk("w1_busy_hold", 32'(busy), 32'd1);
        step();
        chk_idle("w1_end");
        chk("w1_busy_end", 32'(busy), 32'd0);

        // Five back-to-back writes from cnt 4; FIFO fills after the fourth
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'd0, 5'(i), 8'h20 + 8'(i));
            chk("burst_ready", 32'(cmd_ready), 32'd1);
            step();
        end
        drive(1'b0, 2'd0, 5'd4, 8'h24);
        chk("burst_full", 32'(cmd_ready), 32'd0);
        goto(HOLD);
        chk("burst_full_pop", 32'(cmd_ready), 32'd0);
        step();
        chk("burst_freed", 32'(cmd_ready), 32'd1);
        chk_bus("burst_0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'h20);
        step();
        cmd_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            goto(HOLD + 1);
            chk_bus("burst_n", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'(i), 8'h20 + 8'(i));
        end
        goto(HOLD + 1);
        chk_idle("burst_end");
        chk("burst_busy_end", 32'(busy), 32'd0);

        // DE00 write: io1 select only
        drive(1'b0, 2'd3, 5'd0, 8'h55);
        step();
        cmd_valid = 1'b0;
        goto(HOLD + 1);
        chk_bus("io1_launch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h55);
        goto(DIV / 2);
        chk_bus("io1_hi", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h55);
        goto(HOLD);
        chk_bus("io1_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h55);
        step();
        chk_idle("io1_end");

`ifdef SID_BUS_READ_EN
        // Read D420/0x1B returning 0xA5
        data_i = 8'hA5;
        drive(1'b1, 2'd1, 5'h1B, 8'h77);
        step();
        cmd_valid = 1'b0;
        goto(HOLD + 1);
        chk_bus("rd_launch", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'h1B, 8'h00);
        goto(DIV - 1);
        chk("rd_vld_early", 32'(rd_valid), 32'd0);
        step();
        chk("rd_vld", 32'(rd_valid), 32'd1);
        chk("rd_data", 32'(rd_data), 32'hA5);
        step();
        chk("rd_vld_once", 32'(rd_valid), 32'd0);
        data_i = 8'h00;
        goto(HOLD + 1);
        chk_idle("rd_end");
        chk("rd_data_hold", 32'(rd_data), 32'hA5);
`else
        // Read is dropped; only the following write reaches the bus
        drive(1'b1, 2'd1, 5'h1B, 8'h77);
        step();
        drive(1'b0, 2'd0, 5'h04, 8'h41);
        step();
        cmd_valid = 1'b0;
        goto(HOLD + 1);
        chk_bus("nrd_write", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h04, 8'h41);
        goto(0);
        chk("nrd_vld", 32'(rd_valid), 32'd0);
        chk("nrd_data", 32'(rd_data), 32'd0);
        goto(HOLD + 1);
        chk_idle("nrd_end");
`endif

        // Reset mid-transaction with three commands queued
`ifdef SID_BUS_READ_EN
        drive(1'b1, 2'd0, 5'h1B, 8'h00);
`else
        drive(1'b0, 2'd0, 5'h1B, 8'h33);
`endif
        step();
        cmd_valid = 1'b0;
        goto(HOLD + 1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd2, 5'(i + 8), 8'h60 + 8'(i));
            step();
        end
        cmd_valid = 1'b0;
        data_i = 8'h5A;
        goto(16);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_ready", 32'(cmd_ready), 32'd1);
        rdv_before = rdv_seen;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_phi2", 32'(phi2), 32'd0);
        chk_idle("mrst_bus");
        chk("mrst_ready", 32'(cmd_ready), 32'd1);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_rdv", 32'(rd_valid), 32'd0);
        goto(HOLD + 1);
        chk_idle("mrst_flushed");
        goto(HOLD + 1);
        chk_idle("mrst_flushed2");
        chk("mrst_busy2", 32'(busy), 32'd0);
        chk("mrst_no_rdv", 32'(rdv_seen), 32'(rdv_before));

`ifdef SID_BUS_READ_EN
        chk("rdv_total", 32'(rdv_seen), 32'd1);
`else
        chk("rdv_total", 32'(rdv_seen), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
